wos_rank_select: RTL

- Output stage of the weighted-order-statistics kernel. Sits directly downstream of the masked rank generator.
- Keeps an N-deep sample window aligned with the per-position ranks the generator produces, and finds the masked position whose rank equals the requested order.
- Emits that sample as the filter result with a valid strobe.
- Also flags windows where no position matches, and suppresses output until the window has filled.

---
 rtl/wos_rank_select.sv | 108 ++++++++++
 1 files changed

// File: rtl/wos_rank_select.sv
// Output stage of the weighted-order-statistics kernel: picks the masked window sample whose rank equals 'order'.
// Optional build macro WOS_SELECT_ORDER_CLAMP_EN clamps the order into [1, popcount(mask)].
module wos_rank_select #(
  parameter int N = 7,
  parameter int W = 8,
  localparam int RB = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [W-1:0]    sample_in,
  input  logic [N*RB-1:0] ranks_in,
  input  logic [N-1:0]    mask,
  input  logic [RB-1:0]   order,
  output logic            out_valid,
  output logic [W-1:0]    data_out,
  output logic            out_err,
  output logic            filled
);

  logic [W-1:0]  win_q [N];
  logic [RB-1:0] count_q, count_d;
  logic          v1_q;
  logic          out_valid_q;
  logic [W-1:0]  data_q;
  logic          out_err_q;

  logic [RB-1:0] eff_order;
  logic [N-1:0]  hit;
  logic          hit_any;
  logic          err;
  logic [W-1:0]  sel;
  logic          filled_w;

  assign filled_w = (count_q == RB'(N));

`ifdef WOS_SELECT_ORDER_CLAMP_EN
  logic [RB-1:0] pop;

  always_comb begin
    pop = '0;
    for (int j = 0; j < N; j++) begin
      pop = pop + RB'(mask[j]);
    end
  end

  always_comb begin
    eff_order = order;
    if (eff_order == '0) eff_order = RB'(1);
    if (eff_order > pop) eff_order = pop;
  end

  // With a clamped order only an empty mask can leave nothing to select.
  assign err = ~|mask;
`else
  assign eff_order = order;
  assign err       = ~hit_any;
`endif

  for (genvar gi = 0; gi < N; gi++) begin : g_hit
    assign hit[gi] = mask[gi] & (ranks_in[gi*RB +: RB] == eff_order) & (eff_order != '0);
  end

  assign hit_any = |hit;

  // Scan from the top so the lowest matching index wins on malformed ranks.
  always_comb begin
    sel = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (hit[j]) sel = win_q[j];
    end
  end

  always_comb begin
    count_d = count_q;
    if (in_valid && !filled_w) count_d = count_q + RB'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < N; j++) win_q[j] <= '0;
      count_q     <= '0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      out_err_q   <= 1'b0;
    end else begin
      if (in_valid) begin
        for (int j = 0; j < N - 1; j++) win_q[j] <= win_q[j+1];
        win_q[N-1] <= sample_in;
      end
      count_q     <= count_d;
      v1_q        <= in_valid;
      // Ranks seen now describe the window before this edge's shift.
      out_valid_q <= v1_q & filled_w;
      if (v1_q && filled_w) begin
        out_err_q <= err;
        if (hit_any) data_q <= sel;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign out_err   = out_err_q;
  assign filled    = filled_w;

endmodule
